// File: rtl/board_matrix_scanner_if.sv
// Write/swap handshake and scan outputs of the board matrix scanner, grouped.
// A transfer happens on a rising edge where wr_valid && wr_ready are both high; wr_valid, wr_col and wr_data are sampled on that edge.
interface board_matrix_scanner_if #(
  parameter int N = 16
);
  localparam int CW = $clog2(N);

  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_col;
  logic [N-1:0]  wr_data;
  logic          swap_req;
  logic          swap_done;
  logic [N-1:0]  scanline_vertical;
  logic [N-1:0]  scanline_horizontal;
  logic          frame_start;
  logic          scan_active;

  modport master (
    output wr_valid, wr_col, wr_data, swap_req,
    input  wr_ready, swap_done, scanline_vertical, scanline_horizontal,
    input  frame_start, scan_active
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, swap_req,
    output wr_ready, swap_done, scanline_vertical, scanline_horizontal,
    output frame_start, scan_active
  );
endinterface

// File: rtl/board_matrix_scanner.sv
// Double-buffered N x N matrix scanner: drives one column for DWELL clocks,
// blanks for BLANK clocks, and exchanges front/back buffers on frame boundaries.
module board_matrix_scanner #(
  parameter int N     = 16,
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  board_matrix_scanner_if.slave bus
);
  localparam int CW         = $clog2(N);
  localparam int DWELL_LAST = DWELL - 1;
  localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int CNT_MAX    = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  typedef enum logic {S_ACTIVE = 1'b0, S_BLANK = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    col, col_n, col_inc;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             running;
  logic             boundary;
  logic             pending, pending_n;
  logic             front_sel, front_sel_n;
  logic             swap_now;
  logic             wr_fire;
  logic [N-1:0]     mem [2][N];

  logic [N-1:0]     vert_q, vert_n;
  logic [N-1:0]     horiz_q, horiz_n;
  logic             frame_start_q, swap_done_q, wr_ready_q, wr_ready_n;

  assign col_inc = (col == CW'(N - 1)) ? '0 : col + CW'(1);
  assign wr_fire = bus.wr_valid && wr_ready_q && ({1'b0, bus.wr_col} < (CW + 1)'(N));

  // The first clock out of reset is treated as a frame boundary into column 0.
  always_comb begin
    state_n  = state;
    col_n    = col;
    cnt_n    = cnt;
    boundary = 1'b0;
    if (!running) begin
      state_n  = S_ACTIVE;
      col_n    = '0;
      cnt_n    = '0;
      boundary = 1'b1;
    end else if (state == S_ACTIVE) begin
      if (cnt == CNT_W'(DWELL_LAST)) begin
        cnt_n = '0;
        if (BLANK == 0) begin
          col_n    = col_inc;
          boundary = (col == CW'(N - 1));
        end else begin
          state_n = S_BLANK;
        end
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end else begin
      if (cnt == CNT_W'(BLANK_LAST)) begin
        state_n  = S_ACTIVE;
        col_n    = col_inc;
        cnt_n    = '0;
        boundary = (col == CW'(N - 1));
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are computed from the next state so they register in step with it;
  // column 0 of a swapping frame is read straight from the new front buffer.
  always_comb begin
    swap_now    = boundary && pending;
    pending_n   = swap_now ? 1'b0 : (pending || bus.swap_req);
    front_sel_n = front_sel ^ swap_now;
    wr_ready_n  = !(pending_n || swap_now);
    vert_n      = '0;
    horiz_n     = '0;
    if (state_n == S_ACTIVE) begin
      vert_n  = N'(1) << col_n;
      horiz_n = mem[front_sel_n][col_n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_BLANK;
      col           <= '0;
      cnt           <= '0;
      running       <= 1'b0;
      pending       <= 1'b0;
      front_sel     <= 1'b0;
      vert_q        <= '0;
      horiz_q       <= '0;
      frame_start_q <= 1'b0;
      swap_done_q   <= 1'b0;
      wr_ready_q    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      state         <= state_n;
      col           <= col_n;
      cnt           <= cnt_n;
      running       <= 1'b1;
      pending       <= pending_n;
      front_sel     <= front_sel_n;
      vert_q        <= vert_n;
      horiz_q       <= horiz_n;
      frame_start_q <= boundary;
      swap_done_q   <= swap_now;
      wr_ready_q    <= wr_ready_n;
      if (wr_fire) begin
        mem[~front_sel][bus.wr_col] <= bus.wr_data;
      end
    end
  end

  assign bus.scanline_vertical   = vert_q;
  assign bus.scanline_horizontal = horiz_q;
  assign bus.frame_start         = frame_start_q;
  assign bus.swap_done           = swap_done_q;
  assign bus.wr_ready            = wr_ready_q;
  assign bus.scan_active         = running && (state == S_ACTIVE);
endmodule

// File: tb/tb_board_matrix_scanner.sv
// Bench for board_matrix_scanner: a 4x4 (DWELL=3, BLANK=2) instance checked
// against a frame-position model, plus a 16-column DWELL=1 BLANK=0 walker.
module tb_board_matrix_scanner;
  localparam int A_N = 4, A_D = 3, A_B = 2;
  localparam int A_COL = A_D + A_B;
  localparam int A_FRAME = A_N * A_COL;
  localparam int B_N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_matrix_scanner_if #(.N(A_N)) bus_a ();
  board_matrix_scanner_if #(.N(B_N)) bus_b ();

  board_matrix_scanner #(.N(A_N), .DWELL(A_D), .BLANK(A_B)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  board_matrix_scanner #(.N(B_N), .DWELL(1), .BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: everything follows from the cycle count since reset.
  int         m_t = -1;
  int         m_pos = -1;
  logic [3:0] m_buf [2][A_N];
  int         m_fsel = 0;
  bit         m_pend = 0;
  bit         m_rdy = 0;
  bit         m_sd = 0;
  logic [3:0] m_v = '0, m_h = '0;
  bit         m_fs = 0;
  logic [15:0] m_bv = '0;
  bit         m_bfs = 0;

  always @(posedge clk) begin
    bit swap_now;
    int c;
    bit act;
    if (rst) begin
      m_t = -1; m_pos = -1; m_fsel = 0; m_pend = 0; m_rdy = 0; m_sd = 0;
      for (int b = 0; b < 2; b++) for (int i = 0; i < A_N; i++) m_buf[b][i] = '0;
    end else begin
      if (bus_a.wr_valid && m_rdy) m_buf[1 - m_fsel][bus_a.wr_col] = bus_a.wr_data;
      m_t++;
      m_pos = m_t % A_FRAME;
      swap_now = (m_pos == 0) && m_pend;
      if (swap_now) begin
        m_fsel = 1 - m_fsel;
        m_pend = 0;
      end else if (bus_a.swap_req) begin
        m_pend = 1;
      end
      m_rdy = !(m_pend || swap_now);
      m_sd = swap_now;
    end
    if (m_t < 0) begin
      m_v = '0; m_h = '0; m_fs = 0; m_bv = '0; m_bfs = 0;
    end else begin
      c = m_pos / A_COL;
      act = (m_pos % A_COL) < A_D;
      m_v = act ? 4'(1 << c) : 4'b0;
      m_h = act ? m_buf[m_fsel][c] : 4'b0;
      m_fs = (m_pos == 0);
      m_bv = 16'(1 << (m_t % B_N));
      m_bfs = (m_t % B_N) == 0;
    end
  end

  always @(negedge clk) begin
    check("model_vert", 32'(bus_a.scanline_vertical), 32'(m_v));
    check("model_horiz", 32'(bus_a.scanline_horizontal), 32'(m_h));
    check("model_frame_start", 32'(bus_a.frame_start), 32'(m_fs));
    check("model_swap_done", 32'(bus_a.swap_done), 32'(m_sd));
    check("model_wr_ready", 32'(bus_a.wr_ready), 32'(m_rdy));
    check("model_b_vert", 32'(bus_b.scanline_vertical), 32'(m_bv));
    check("model_b_frame_start", 32'(bus_b.frame_start), 32'(m_bfs));
  end

  typedef struct {
    int         cyc;
    logic [3:0] vert;
    logic [3:0] horiz;
    logic       fs;
    logic       rdy;
  } vec_t;
  vec_t vecs [13];

  logic [7:0] exp_q [$];

  task automatic wait_pos(input int p, input int maxc, input string name);
    bit found = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (m_pos == p) begin
        found = 1;
        break;
      end
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sd_cnt;
    bit found;
    logic [3:0] ev, eh;

    vecs[0]  = '{0,  4'b0001, 4'b0, 1'b1, 1'b1};
    vecs[1]  = '{1,  4'b0001, 4'b0, 1'b0, 1'b1};
    vecs[2]  = '{2,  4'b0001, 4'b0, 1'b0, 1'b1};
    vecs[3]  = '{3,  4'b0000, 4'b0, 1'b0, 1'b1};
    vecs[4]  = '{4,  4'b0000, 4'b0, 1'b0, 1'b1};
    vecs[5]  = '{5,  4'b0010, 4'b0, 1'b0, 1'b1};
    vecs[6]  = '{7,  4'b0010, 4'b0, 1'b0, 1'b1};
    vecs[7]  = '{8,  4'b0000, 4'b0, 1'b0, 1'b1};
    vecs[8]  = '{10, 4'b0100, 4'b0, 1'b0, 1'b1};
    vecs[9]  = '{13, 4'b0000, 4'b0, 1'b0, 1'b1};
    vecs[10] = '{15, 4'b1000, 4'b0, 1'b0, 1'b1};
    vecs[11] = '{19, 4'b0000, 4'b0, 1'b0, 1'b1};
    vecs[12] = '{20, 4'b0001, 4'b0, 1'b1, 1'b1};

    bus_a.wr_valid = 0; bus_a.wr_col = '0; bus_a.wr_data = '0; bus_a.swap_req = 0;
    bus_b.wr_valid = 0; bus_b.wr_col = '0; bus_b.wr_data = '0; bus_b.swap_req = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vert", 32'(bus_a.scanline_vertical), 32'd0);
    check("rst_horiz", 32'(bus_a.scanline_horizontal), 32'd0);
    check("rst_frame_start", 32'(bus_a.frame_start), 32'd0);
    check("rst_wr_ready", 32'(bus_a.wr_ready), 32'd0);
    rst = 0;

    // Free-running scan with empty buffers, plus the 16-column walker
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c) begin
          check("tbl_vert", 32'(bus_a.scanline_vertical), 32'(vecs[i].vert));
          check("tbl_horiz", 32'(bus_a.scanline_horizontal), 32'(vecs[i].horiz));
          check("tbl_frame_start", 32'(bus_a.frame_start), 32'(vecs[i].fs));
          check("tbl_wr_ready", 32'(bus_a.wr_ready), 32'(vecs[i].rdy));
        end
      end
      check("walk16", 32'(bus_b.scanline_vertical), 32'(1) << (c % 16));
    end

    // Write column 2 then swap: 1010 shows only while column 2 is driven
    bus_a.wr_valid = 1; bus_a.wr_col = 2'd2; bus_a.wr_data = 4'b1010;
    @(negedge clk);
    bus_a.wr_valid = 0; bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.swap_done) begin
        found = 1;
        break;
      end
    end
    check("swap1_seen", 32'(found), 32'd1);
    check("swap1_with_frame_start", 32'(bus_a.frame_start), 32'd1);
    for (int k = 0; k < A_FRAME; k++) begin
      ev = ((k % A_COL) < A_D) ? 4'(1 << (k / A_COL)) : 4'b0;
      eh = (ev == 4'b0100) ? 4'b1010 : 4'b0000;
      exp_q.push_back({ev, eh});
    end
    for (int k = 0; k < A_FRAME; k++) begin
      if (k > 0) @(negedge clk);
      check("frame_after_swap", 32'({bus_a.scanline_vertical, bus_a.scanline_horizontal}),
            32'(exp_q.pop_front()));
    end

    // Swap requested mid column 1: ready drops, old image held until boundary
    wait_pos(6, 40, "reach_col1");
    check("rdy_before_swap2", 32'(bus_a.wr_ready), 32'd1);
    bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_pos == 0) break;
      check("rdy_low_pending", 32'(bus_a.wr_ready), 32'd0);
      check("no_early_done", 32'(bus_a.swap_done), 32'd0);
      if (m_pos == 10) check("old_front_kept", 32'(bus_a.scanline_horizontal), 32'hA);
      @(negedge clk);
    end
    check("swap2_done", 32'(bus_a.swap_done), 32'd1);
    check("swap2_frame_start", 32'(bus_a.frame_start), 32'd1);
    check("swap2_rdy_still_low", 32'(bus_a.wr_ready), 32'd0);
    @(negedge clk);
    check("swap2_rdy_back", 32'(bus_a.wr_ready), 32'd1);

    // Second request while pending is ignored; exchange brings 1010 back
    bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    repeat (2) @(negedge clk);
    bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    sd_cnt = 0;
    for (int i = 0; i < 2 * A_FRAME; i++) begin
      @(negedge clk);
      if (bus_a.swap_done) sd_cnt++;
      if (m_pos == 10 && sd_cnt > 0)
        check("exchange_restores", 32'(bus_a.scanline_horizontal), 32'hA);
    end
    check("single_swap", 32'(sd_cnt), 32'd1);

    // Request raised in the frame_start cycle lands one frame later
    wait_pos(0, 25, "reach_boundary");
    bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      if (bus_a.swap_done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("boundary_defer", 32'(lat), 32'd20);

    // Random writes and swaps against the model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus_a.wr_valid = 1'($urandom_range(0, 1));
      bus_a.wr_col = 2'($urandom_range(0, 3));
      bus_a.wr_data = 4'($urandom_range(0, 15));
      bus_a.swap_req = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    bus_a.wr_valid = 0; bus_a.swap_req = 0;

    // Reset during a pending swap in column 3
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_rdy) begin
        found = 1;
        break;
      end
    end
    check("ready_for_col3_write", 32'(found), 32'd1);
    bus_a.wr_valid = 1; bus_a.wr_col = 2'd3; bus_a.wr_data = 4'b1111;
    @(negedge clk);
    bus_a.wr_valid = 0;
    wait_pos(15, 25, "reach_col3");
    check("col3_driven", 32'(bus_a.scanline_vertical), 32'h8);
    bus_a.swap_req = 1;
    @(negedge clk);
    bus_a.swap_req = 0;
    check("pending_before_rst", 32'(bus_a.wr_ready), 32'd0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst2_vert", 32'(bus_a.scanline_vertical), 32'd0);
      check("rst2_horiz", 32'(bus_a.scanline_horizontal), 32'd0);
      check("rst2_swap_done", 32'(bus_a.swap_done), 32'd0);
      check("rst2_wr_ready", 32'(bus_a.wr_ready), 32'd0);
    end
    rst = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      check("post_rst_no_swap", 32'(bus_a.swap_done), 32'd0);
      check("post_rst_blank", 32'(bus_a.scanline_horizontal), 32'd0);
      if (c == 0) begin
        check("post_rst_frame_start", 32'(bus_a.frame_start), 32'd1);
        check("post_rst_col0", 32'(bus_a.scanline_vertical), 32'd1);
        check("post_rst_wr_ready", 32'(bus_a.wr_ready), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
